// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer
//
// Feeds the 10010 sequence detector: takes parallel words over a valid/ready
// handshake and shifts them out one bit per clock on a single serial line.
// A one-word holding buffer lets consecutive words leave with no idle gap;
// between words the line sits at IDLE_BIT.
//
// Parameters:
//   WIDTH      word width in bits (>= 2)
//   MSB_FIRST  1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
//   IDLE_BIT   level on sout while no word is being shifted
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   din         parallel word
//   din_valid   din holds a word
//   din_ready   a word can be taken this cycle (registered state only)
//   sout        serial bit, drives the detector's ain
//   sout_valid  sout carries a data bit
//   word_done   pulse during the last bit of each word
//   underrun    pulse during a last bit when no next word is available

module seq_bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             word_done,
  output logic             underrun
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;

  logic             xfer;
  logic             last_bit;
  logic [WIDTH-1:0] sh_shifted;

  // State register: every flop of the block lives here. Reset drops both the
  // in-flight word and the held word so nothing partial leaves afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sh_q        <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  // Next-state logic. An accepted word goes straight into the shifter when
  // the shifter is free at the next edge (idle, or finishing its last bit
  // with nothing held); otherwise it parks in the holding register. A held
  // word always wins the shifter over a newly arriving one.
  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;

    xfer     = din_valid && !hold_full_q;
    last_bit = (state_q == ST_SHIFT) && (cnt_q == LAST_CNT);

    // The shifter always moves toward the end that drives sout.
    if (MSB_FIRST) begin
      sh_shifted = {sh_q[WIDTH-2:0], 1'b0};
    end else begin
      sh_shifted = {1'b0, sh_q[WIDTH-1:1]};
    end

    unique case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          sh_d    = din;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (!last_bit) begin
          sh_d  = sh_shifted;
          cnt_d = cnt_q + 1'b1;
          if (xfer) begin
            hold_d      = din;
            hold_full_d = 1'b1;
          end
        end else if (hold_full_q) begin
          // din_ready is low here, so hold cannot also be refilled this edge.
          sh_d        = hold_q;
          cnt_d       = '0;
          hold_full_d = 1'b0;
        end else if (xfer) begin
          sh_d  = din;
          cnt_d = '0;
        end else begin
          sh_d    = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic. Everything except underrun depends on registered state
  // only, so the detector's input never sees a path from din/din_valid.
  always_comb begin
    din_ready  = !hold_full_q;
    sout_valid = (state_q == ST_SHIFT);
    word_done  = (state_q == ST_SHIFT) && (cnt_q == LAST_CNT);
    underrun   = word_done && !hold_full_q && !(din_valid && !hold_full_q);

    if (state_q == ST_SHIFT) begin
      sout = MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0];
    end else begin
      sout = IDLE_BIT;
    end
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// tb_seq_bit_serializer
//
// Drives two serializers sharing one clock and reset: one MSB-first and one
// LSB-first. Inputs change on the falling edge; outputs are observed on the
// falling edge, i.e. half a cycle after the rising edge that produced them.
// Observed vector order: {sout_valid, sout, din_ready, word_done, underrun}.

module tb_seq_bit_serializer;

  logic       clk = 1'b0;
  logic       rst;

  logic [7:0] m_din;
  logic       m_valid;
  logic       m_ready, m_sout, m_sout_valid, m_word_done, m_underrun;

  logic [7:0] l_din;
  logic       l_valid;
  logic       l_ready, l_sout, l_sout_valid, l_word_done, l_underrun;

  int total = 0;
  int bad   = 0;

  logic [4:0] obs_m;
  logic [4:0] obs_l;

  assign obs_m = {m_sout_valid, m_sout, m_ready, m_word_done, m_underrun};
  assign obs_l = {l_sout_valid, l_sout, l_ready, l_word_done, l_underrun};

  always #5 clk = ~clk;

  seq_bit_serializer #(
    .WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)
  ) dut_msb (
    .clk        (clk),
    .rst        (rst),
    .din        (m_din),
    .din_valid  (m_valid),
    .din_ready  (m_ready),
    .sout       (m_sout),
    .sout_valid (m_sout_valid),
    .word_done  (m_word_done),
    .underrun   (m_underrun)
  );

  seq_bit_serializer #(
    .WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)
  ) dut_lsb (
    .clk        (clk),
    .rst        (rst),
    .din        (l_din),
    .din_valid  (l_valid),
    .din_ready  (l_ready),
    .sout       (l_sout),
    .sout_valid (l_sout_valid),
    .word_done  (l_word_done),
    .underrun   (l_underrun)
  );

  // Reset held two cycles with a word offered: nothing is taken until rst
  // falls, and the first bit appears right after the first free edge.
  task automatic test_reset();
    logic [4:0] e;
    rst     = 1'b1;
    m_din   = 8'h93;
    m_valid = 1'b1;
    l_din   = 8'h00;
    l_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      e = 5'b0_0_1_0_0;
      total++;
      if (obs_m !== e) begin
        bad++;
        $display("[TB] FAIL reset cycle %0d: got %b want %b", i, obs_m, e);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    m_valid = 1'b0;
    e = 5'b1_1_1_0_0;
    total++;
    if (obs_m !== e) begin
      bad++;
      $display("[TB] FAIL reset first_xfer: got %b want %b", obs_m, e);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    e = 5'b0_0_1_0_0;
    total++;
    if (obs_m !== e) begin
      bad++;
      $display("[TB] FAIL reset flush: got %b want %b", obs_m, e);
    end
  endtask

  // One word 8'h93 MSB-first: 1,0,0,1,0,0,1,1 then idle.
  task automatic test_single();
    logic [7:0] bits;
    logic [4:0] e;
    bits    = 8'b1001_0011;
    m_din   = 8'h93;
    m_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      m_valid = 1'b0;
      e = {1'b1, bits[7-i], 1'b1, (i == 7), (i == 7)};
      total++;
      if (obs_m !== e) begin
        bad++;
        $display("[TB] FAIL single bit %0d: got %b want %b", i, obs_m, e);
      end
    end
    @(negedge clk);
    e = 5'b0_0_1_0_0;
    total++;
    if (obs_m !== e) begin
      bad++;
      $display("[TB] FAIL single idle_after: got %b want %b", obs_m, e);
    end
  endtask

  // LSB-first instance, 8'h01 leaves as 1 followed by seven 0s.
  task automatic test_lsb_first();
    logic [7:0] bits;
    logic [4:0] e;
    bits    = 8'b1000_0000;
    l_din   = 8'h01;
    l_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      l_valid = 1'b0;
      e = {1'b1, bits[7-i], 1'b1, (i == 7), (i == 7)};
      total++;
      if (obs_l !== e) begin
        bad++;
        $display("[TB] FAIL lsb bit %0d: got %b want %b", i, obs_l, e);
      end
    end
    @(negedge clk);
    e = 5'b0_0_1_0_0;
    total++;
    if (obs_l !== e) begin
      bad++;
      $display("[TB] FAIL lsb idle_after: got %b want %b", obs_l, e);
    end
  endtask

  // Three words with valid held high: 24 contiguous bits, ready low while
  // hold is occupied, underrun only after the last word.
  task automatic test_back_to_back();
    logic [7:0]  words [3];
    logic [23:0] stream;
    logic [4:0]  e;
    logic        fire;
    int          idx;
    words[0] = 8'h12;
    words[1] = 8'h48;
    words[2] = 8'hA5;
    stream   = 24'b00010010_01001000_10100101;
    idx      = 0;
    m_din    = words[0];
    m_valid  = 1'b1;
    fire     = m_ready;
    for (int j = 1; j <= 24; j++) begin
      @(negedge clk);
      if (fire) idx++;
      if (idx < 3) begin
        m_din   = words[idx];
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
      e = {1'b1, stream[24-j], (j == 1 || j == 9 || j >= 17),
           (j % 8 == 0), (j == 24)};
      total++;
      if (obs_m !== e) begin
        bad++;
        $display("[TB] FAIL b2b cycle %0d: got %b want %b", j, obs_m, e);
      end
      fire = m_valid && m_ready;
    end
    @(negedge clk);
    m_valid = 1'b0;
    e = 5'b0_0_1_0_0;
    total++;
    if (obs_m !== e) begin
      bad++;
      $display("[TB] FAIL b2b idle_after: got %b want %b", obs_m, e);
    end
  endtask

  // Word A shifting, B fills hold, C waits with ready low until B moves into
  // the shifter; C is then taken and follows B with no lost or repeated bit.
  task automatic test_stall();
    logic [7:0]  words [3];
    logic [23:0] stream;
    logic [4:0]  e;
    logic        fire;
    int          idx;
    words[0] = 8'hC3;
    words[1] = 8'h5A;
    words[2] = 8'h0F;
    stream   = 24'b11000011_01011010_00001111;
    idx      = 0;
    m_din    = words[0];
    m_valid  = 1'b1;
    fire     = m_ready;
    for (int j = 1; j <= 24; j++) begin
      @(negedge clk);
      if (fire) idx++;
      if (idx < 3 && !(idx == 1 && j < 3)) begin
        m_din   = words[idx];
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
      e = {1'b1, stream[24-j], (j <= 3 || j == 9 || j >= 17),
           (j % 8 == 0), (j == 24)};
      total++;
      if (obs_m !== e) begin
        bad++;
        $display("[TB] FAIL stall cycle %0d: got %b want %b", j, obs_m, e);
      end
      fire = m_valid && m_ready;
    end
    @(negedge clk);
    m_valid = 1'b0;
    e = 5'b0_0_1_0_0;
    total++;
    if (obs_m !== e) begin
      bad++;
      $display("[TB] FAIL stall idle_after: got %b want %b", obs_m, e);
    end
  endtask

  // 8'hFF shifting with a second 8'hFF held; reset at bit 3 discards both.
  task automatic test_reset_mid_word();
    logic [4:0] e;
    m_din   = 8'hFF;
    m_valid = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      if (j >= 2) m_valid = 1'b0;
      e = {1'b1, 1'b1, (j == 1), 1'b0, 1'b0};
      total++;
      if (obs_m !== e) begin
        bad++;
        $display("[TB] FAIL rstmid bit %0d: got %b want %b", j - 1, obs_m, e);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    e = 5'b0_0_1_0_0;
    total++;
    if (obs_m !== e) begin
      bad++;
      $display("[TB] FAIL rstmid after_reset: got %b want %b", obs_m, e);
    end
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      total++;
      if (obs_m !== e) begin
        bad++;
        $display("[TB] FAIL rstmid quiet %0d: got %b want %b", j, obs_m, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_lsb_first();
    test_back_to_back();
    test_stall();
    test_reset_mid_word();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
